shared_reg_rr_arbiter: RTL and testbench
========================================

// Module: shared_reg_rr_arbiter
// PURPOSE
//  Shares one WIDTH-bit async-reset data register between NREQ requesters.
//  Round-robin arbiter picks one requester per write slot, loads its data into the register, and returns a one-cycle grant as acknowledge.
//  Sits in front of the shared storage flop: writers never touch q directly; readers observe q/q_valid.
// PARAMETERS
//  NREQ   4   number of requesters (>=2)
//  WIDTH  8   data/register width in bits
// PORTS
//  clk      in   1           clock, rising edge
//  rst      in   1           asynchronous reset, active-low
//  req      in   NREQ        level request, bit i = requester i
//  wdata    in   NREQ*WIDTH  write data, slice i = wdata[i*WIDTH +: WIDTH]
//  clr      in   1           synchronous clear of shared register
//  gnt      out  NREQ        registered one-hot grant/ack, one cycle wide
//  q        out  WIDTH       shared register contents
//  q_valid  out  1           q holds data written since reset/clr
//  owner    out  log2(NREQ)  index of requester that last wrote q
//  wr_cnt   out  8           accepted-write counter, wraps 255->0
// BEHAVIOUR
//  - Reset (rst=0, async, any time): q=0, q_valid=0, gnt=0, owner=0, wr_cnt=0, state=IDLE, last=NREQ-1 (req 0 highest priority first).
//    Reset mid-operation aborts a pending grant.
//  - FSM states: IDLE, HOLD.
//    IDLE: if clr=1 -> q<=0, q_valid<=0, gnt<=0, stay IDLE; pointer unchanged; no grant even if req!=0.
//    IDLE: else if req!=0 -> winner w = first set bit scanning last+1, last+2, ... mod NREQ.
//      At the edge: q<=wdata slice w, q_valid<=1, gnt<=onehot(w), owner<=w, last<=w, wr_cnt<=wr_cnt+1, state<=HOLD.
//    IDLE: else req=0 -> no change, gnt=0.
//    HOLD: exactly one cycle, gnt visible high; req ignored. At the edge: gnt<=0, state<=IDLE.
//      If clr=1 in HOLD, q/q_valid clear at that edge; the grant already issued stands.
//  - Latency: req sampled in cycle n -> q updated and gnt high in cycle n+1.
//    Max throughput is one write per 2 cycles.
//  - Requester protocol: on seeing gnt[i]=1, requester i drops req[i] by the next edge or issues a new write with new wdata.
//    A req still high in the following IDLE cycle is a new request.
//    wdata slice must be stable while req is high.
//  - Fairness: a continuously requesting agent waits at most NREQ-1 other writes.
//    The winner becomes lowest priority next slot.
//  - gnt is zero or one-hot at all times; never asserted in two consecutive cycles.
//  - wr_cnt counts grants only, unaffected by clr; wraps 8'hFF->8'h00 silently.
//  - owner holds the last winner; owner is not cleared by clr.
// TESTING
//  1 Reset: hold rst=0, toggle clk, drive req=4'hF -> q=0, q_valid=0, gnt=0, wr_cnt=0; release rst -> first gnt=4'b0001.
//  2 Single: req=4'b0100, wdata[2]=8'hA5 for 1 cycle -> next cycle gnt=4'b0100, q=8'hA5, owner=2, q_valid=1; following cycle gnt=0.
//  3 Rotation: req=4'hF held, distinct data 8'h10..8'h13 -> grants 0,1,2,3,0 on every other cycle; q tracks matching data; wr_cnt=5.
//  4 Clear collision: in IDLE drive clr=1 and req=4'b0010 together -> q=0, q_valid=0, gnt=0; next cycle req still high -> gnt=4'b0010.
//  5 Reset mid-op: assert rst=0 while gnt=4'b1000 (HOLD) -> gnt, q, q_valid, wr_cnt go 0 immediately; after release, req=4'hF grants req 0.
//  6 Wrap: perform 256 single writes -> wr_cnt returns to 8'h00; q shows last write's data.

Source files
------------

// File: rtl/shared_reg_rr_arbiter.sv
// Round-robin arbiter that serialises NREQ writers onto one shared register.
// Grants are one-cycle acks; the register clears synchronously on clr.
module shared_reg_rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
    input  logic                  clr,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      q,
    output logic                  q_valid,
    output logic [IW-1:0]         owner,
    output logic [7:0]            wr_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t state;

    logic [IW-1:0]    last;
    logic             found;
    logic [IW-1:0]    win;
    logic [NREQ-1:0]  win_oh;
    logic [WIDTH-1:0] win_data;
    int               idx;

    // Scan starts just past the previous winner, so it ranks lowest next.
    always_comb begin
        found    = 1'b0;
        win      = '0;
        win_oh   = '0;
        win_data = '0;
        idx      = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last) + k) % NREQ;
            if (!found && req[idx]) begin
                found       = 1'b1;
                win         = IW'(idx);
                win_oh[idx] = 1'b1;
                win_data    = wdata[idx*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            q       <= '0;
            q_valid <= 1'b0;
            gnt     <= '0;
            owner   <= '0;
            wr_cnt  <= 8'd0;
            last    <= IW'(NREQ - 1);
        end else begin
            unique case (state)
                IDLE: begin
                    if (clr) begin
                        q       <= '0;
                        q_valid <= 1'b0;
                        gnt     <= '0;
                    end else if (found) begin
                        q       <= win_data;
                        q_valid <= 1'b1;
                        gnt     <= win_oh;
                        owner   <= win;
                        last    <= win;
                        wr_cnt  <= wr_cnt + 8'd1;
                        state   <= HOLD;
                    end else begin
                        gnt <= '0;
                    end
                end
                HOLD: begin
                    gnt   <= '0;
                    state <= IDLE;
                    if (clr) begin
                        q       <= '0;
                        q_valid <= 1'b0;
                    end
                end
                default: begin
                    gnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shared_reg_rr_arbiter.sv
// Directed and randomized bench for shared_reg_rr_arbiter.
// A slot-level reference model predicts every output each cycle.
module tb_shared_reg_rr_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] wdata;
    logic                  clr;
    logic [NREQ-1:0]       gnt;
    logic [WIDTH-1:0]      q;
    logic                  q_valid;
    logic [1:0]            owner;
    logic [7:0]            wr_cnt;

    shared_reg_rr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .wdata   (wdata),
        .clr     (clr),
        .gnt     (gnt),
        .q       (q),
        .q_valid (q_valid),
        .owner   (owner),
        .wr_cnt  (wr_cnt)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    int m_q, m_qv, m_owner, m_last, m_cnt, m_gnt;
    bit m_busy;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    function automatic void model_reset();
        m_q = 0; m_qv = 0; m_owner = 0; m_last = NREQ - 1;
        m_cnt = 0; m_gnt = 0; m_busy = 0;
    endfunction

    // One arbitration slot, described in terms of the rules only.
    function automatic void model_edge();
        if (m_busy) begin
            m_busy = 0;
            m_gnt  = 0;
            if (clr) begin m_q = 0; m_qv = 0; end
        end else if (clr) begin
            m_q = 0; m_qv = 0; m_gnt = 0;
        end else if (req != 0) begin
            int w = -1;
            for (int k = 1; k <= NREQ && w < 0; k++)
                if (req[(m_last + k) % NREQ]) w = (m_last + k) % NREQ;
            m_q     = int'(wdata[w*WIDTH +: WIDTH]);
            m_qv    = 1;
            m_gnt   = 1 << w;
            m_owner = w;
            m_last  = w;
            m_cnt   = (m_cnt + 1) % 256;
            m_busy  = 1;
        end else begin
            m_gnt = 0;
        end
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".gnt"}, 32'(gnt), 32'(m_gnt));
        chk({tag, ".q"}, 32'(q), 32'(m_q));
        chk({tag, ".qv"}, 32'(q_valid), 32'(m_qv));
        chk({tag, ".owner"}, 32'(owner), 32'(m_owner));
        chk({tag, ".cnt"}, 32'(wr_cnt), 32'(m_cnt));
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] d;
        rst   = 1'b0;
        req   = 4'hF;
        clr   = 1'b0;
        wdata = {8'h44, 8'h33, 8'h22, 8'h11};
        model_reset();

        // reset held with requests pending
        repeat (3) @(posedge clk);
        #1;
        chk("rst.gnt", 32'(gnt), 32'h0);
        chk("rst.q", 32'(q), 32'h0);
        chk("rst.qv", 32'(q_valid), 32'h0);
        chk("rst.cnt", 32'(wr_cnt), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        step("first");
        chk("first.gnt0", 32'(gnt), 32'h1);
        req = '0;
        step("first.hold");

        // single requester
        req = 4'b0100;
        wdata[2*WIDTH +: WIDTH] = 8'hA5;
        step("single");
        chk("single.gnt", 32'(gnt), 32'h4);
        chk("single.q", 32'(q), 32'hA5);
        chk("single.owner", 32'(owner), 32'd2);
        chk("single.qv", 32'(q_valid), 32'd1);
        req = '0;
        step("single.drop");
        chk("single.gnt0", 32'(gnt), 32'h0);

        // rotation from a fresh pointer
        do_reset();
        wdata = {8'h13, 8'h12, 8'h11, 8'h10};
        req = 4'hF;
        for (int i = 0; i < 5; i++) begin
            step("rot");
            chk("rot.gnt", 32'(gnt), 32'(1 << (i % 4)));
            chk("rot.q", 32'(q), 32'(8'h10 + (i % 4)));
            step("rot.hold");
            chk("rot.gap", 32'(gnt), 32'h0);
        end
        chk("rot.cnt", 32'(wr_cnt), 32'd5);

        // clear colliding with a request in IDLE
        clr = 1'b1;
        req = 4'b0010;
        step("clr");
        chk("clr.q", 32'(q), 32'h0);
        chk("clr.qv", 32'(q_valid), 32'h0);
        chk("clr.gnt", 32'(gnt), 32'h0);
        clr = 1'b0;
        step("clr.next");
        chk("clr.gnt1", 32'(gnt), 32'h2);
        req = '0;
        step("clr.hold");

        // reset while a grant is visible
        req = 4'b1000;
        step("mid");
        chk("mid.gnt", 32'(gnt), 32'h8);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk("mid.gnt0", 32'(gnt), 32'h0);
        chk("mid.q0", 32'(q), 32'h0);
        chk("mid.qv0", 32'(q_valid), 32'h0);
        chk("mid.cnt0", 32'(wr_cnt), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        req = 4'hF;
        step("mid.after");
        chk("mid.gnt_r0", 32'(gnt), 32'h1);
        req = '0;
        step("mid.hold");

        // 256 writes wrap the counter
        do_reset();
        d = 8'h00;
        for (int i = 0; i < 256; i++) begin
            int r = int'($urandom_range(0, NREQ - 1));
            d = 8'($urandom);
            req = '0;
            req[r] = 1'b1;
            wdata[r*WIDTH +: WIDTH] = d;
            model_edge();
            @(posedge clk);
            #1;
            req = '0;
            model_edge();
            @(posedge clk);
            #1;
        end
        chk("wrap.cnt", 32'(wr_cnt), 32'h0);
        chk("wrap.q", 32'(q), 32'(d));
        check_all("wrap");

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            req   = 4'($urandom);
            clr   = ($urandom_range(0, 9) == 0);
            wdata = 32'($urandom);
            step("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
